// File: rtl/sdram_axi_tester.sv
// AXI4 master traffic generator/checker for SDRAM bring-up: writes NUM_BURSTS INCR bursts of an
// incrementing pattern, reads them back, and reports done/pass/error count and LED status.
module sdram_axi_tester #(
  parameter logic [21:0] BASE_ADDR  = 22'h0,
  parameter int          BURST_LEN  = 16,
  parameter int          NUM_BURSTS = 4,
  parameter logic [15:0] SEED       = 16'hA5C3
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        start,
  output logic [7:0]  user_awid,
  output logic [21:0] user_awaddr,
  output logic [7:0]  user_awlen,
  output logic [2:0]  user_awsize,
  output logic [1:0]  user_awburst,
  output logic        user_awvalid,
  input  logic        user_awready,
  output logic [15:0] user_wdata,
  output logic [1:0]  user_wstrb,
  output logic        user_wlast,
  output logic        user_wvalid,
  input  logic        user_wready,
  input  logic [7:0]  user_bid,
  input  logic [1:0]  user_bresp,
  input  logic        user_bvalid,
  output logic        user_bready,
  output logic [7:0]  user_arid,
  output logic [21:0] user_araddr,
  output logic [7:0]  user_arlen,
  output logic [2:0]  user_arsize,
  output logic [1:0]  user_arburst,
  output logic        user_arvalid,
  input  logic        user_arready,
  input  logic [7:0]  user_rid,
  input  logic [15:0] user_rdata,
  input  logic [1:0]  user_rresp,
  input  logic        user_rlast,
  input  logic        user_rvalid,
  output logic        user_rready,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [7:0]  status_led
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AW   = 3'd1;
  localparam logic [2:0] ST_W    = 3'd2;
  localparam logic [2:0] ST_B    = 3'd3;
  localparam logic [2:0] ST_AR   = 3'd4;
  localparam logic [2:0] ST_R    = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [7:0]  LAST_BURST  = 8'(NUM_BURSTS - 1);
  localparam logic [21:0] BURST_BYTES = 22'(BURST_LEN * 2);

  logic [2:0]  state;
  logic [7:0]  burst;
  logic [7:0]  beat;
  logic [15:0] k;
  logic [21:0] addr;
  logic        awvalid_q, wvalid_q, arvalid_q;

  logic [15:0] pattern;
  logic        last_beat;
  logic        err_hit;
  logic [15:0] err_next;

  assign pattern   = SEED + k;
  assign last_beat = (beat == LAST_BEAT);

  // Address channels share one address register; it is reloaded when switching to reads.
  assign user_awid    = burst;
  assign user_awaddr  = addr;
  assign user_awlen   = LAST_BEAT;
  assign user_awsize  = 3'b001;
  assign user_awburst = 2'b01;
  assign user_awvalid = awvalid_q;
  assign user_wdata   = pattern;
  assign user_wstrb   = 2'b11;
  assign user_wlast   = last_beat;
  assign user_wvalid  = wvalid_q;
  assign user_bready  = (state == ST_B);
  assign user_arid    = burst;
  assign user_araddr  = addr;
  assign user_arlen   = LAST_BEAT;
  assign user_arsize  = 3'b001;
  assign user_arburst = 2'b01;
  assign user_arvalid = arvalid_q;
  assign user_rready  = (state == ST_R);
  assign status_led   = {pass, done, (err_count != 16'h0), busy, 1'b0, state};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    err_hit  = 1'b0;
    err_next = err_count;
    if (state == ST_B && user_bvalid)
      err_hit = (user_bresp != 2'b00) || (user_bid != burst);
    else if (state == ST_R && user_rvalid)
      err_hit = (user_rdata != pattern) || (user_rresp != 2'b00) ||
                (user_rid != burst) || (user_rlast != last_beat);
    if (err_hit && err_count != 16'hFFFF)
      err_next = err_count + 16'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= ST_IDLE;
      burst     <= 8'h0;
      beat      <= 8'h0;
      k         <= 16'h0;
      addr      <= 22'h0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 16'h0;
    end else begin
      err_count <= err_next;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_AW;
            awvalid_q <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 16'h0;
            burst     <= 8'h0;
            beat      <= 8'h0;
            k         <= 16'h0;
            addr      <= BASE_ADDR;
          end
        end
        ST_AW: begin
          if (user_awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            state     <= ST_W;
          end
        end
        ST_W: begin
          if (user_wready) begin
            k <= k + 16'd1;
            if (last_beat) begin
              beat     <= 8'h0;
              wvalid_q <= 1'b0;
              state    <= ST_B;
            end else begin
              beat <= beat + 8'd1;
            end
          end
        end
        ST_B: begin
          if (user_bvalid) begin
            if (burst == LAST_BURST) begin
              // Write phase complete: rewind pattern and address for read-back.
              burst     <= 8'h0;
              k         <= 16'h0;
              addr      <= BASE_ADDR;
              arvalid_q <= 1'b1;
              state     <= ST_AR;
            end else begin
              burst     <= burst + 8'd1;
              addr      <= addr + BURST_BYTES;
              awvalid_q <= 1'b1;
              state     <= ST_AW;
            end
          end
        end
        ST_AR: begin
          if (user_arready) begin
            arvalid_q <= 1'b0;
            state     <= ST_R;
          end
        end
        ST_R: begin
          if (user_rvalid) begin
            k <= k + 16'd1;
            if (last_beat) begin
              beat <= 8'h0;
              if (burst == LAST_BURST) begin
                state <= ST_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
                pass  <= (err_next == 16'h0);
              end else begin
                burst     <= burst + 8'd1;
                addr      <= addr + BURST_BYTES;
                arvalid_q <= 1'b1;
                state     <= ST_AR;
              end
            end else begin
              beat <= beat + 8'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_axi_tester.sv
// Self-checking bench: randomised AXI slave with fault injection drives two tester instances
// (default and wrapping base address); logged traffic is checked against an arithmetic model.
module tb_sdram_axi_tester;
  localparam int          L     = 16;
  localparam int          N1    = 4;
  localparam int          N2    = 2;
  localparam logic [21:0] BASE1 = 22'h0;
  localparam logic [21:0] BASE2 = 22'h3FFFF0;
  localparam logic [15:0] SEED  = 16'hA5C3;

  typedef struct packed {
    logic [7:0] awid; logic [21:0] awaddr; logic [7:0] awlen; logic [2:0] awsize; logic [1:0] awburst;
    logic awvalid; logic [15:0] wdata; logic [1:0] wstrb; logic wlast; logic wvalid; logic bready;
    logic [7:0] arid; logic [21:0] araddr; logic [7:0] arlen; logic [2:0] arsize; logic [1:0] arburst;
    logic arvalid; logic rready; logic busy; logic done; logic pass; logic [15:0] err_count;
    logic [7:0] status_led;
  } dut_o_t;
  typedef struct packed {logic [7:0] id; logic [21:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;} a_log_t;
  typedef struct packed {logic [15:0] data; logic [1:0] strb; logic last;} w_log_t;

  logic clk = 1'b0;
  logic rst_n, start, sel;
  logic awready, wready, arready, bvalid, rvalid, rlast;
  logic [7:0] bid, rid;
  logic [1:0] bresp, rresp;
  logic [15:0] rdata;
  dut_o_t o1, o2, o;

  always #5 clk = ~clk;
  assign o = sel ? o2 : o1;

  sdram_axi_tester u_dut1 (
    .clk_clk(clk), .reset_reset_n(rst_n), .start(start & ~sel),
    .user_awid(o1.awid), .user_awaddr(o1.awaddr), .user_awlen(o1.awlen), .user_awsize(o1.awsize),
    .user_awburst(o1.awburst), .user_awvalid(o1.awvalid), .user_awready(awready),
    .user_wdata(o1.wdata), .user_wstrb(o1.wstrb), .user_wlast(o1.wlast), .user_wvalid(o1.wvalid),
    .user_wready(wready), .user_bid(bid), .user_bresp(bresp), .user_bvalid(bvalid), .user_bready(o1.bready),
    .user_arid(o1.arid), .user_araddr(o1.araddr), .user_arlen(o1.arlen), .user_arsize(o1.arsize),
    .user_arburst(o1.arburst), .user_arvalid(o1.arvalid), .user_arready(arready),
    .user_rid(rid), .user_rdata(rdata), .user_rresp(rresp), .user_rlast(rlast), .user_rvalid(rvalid),
    .user_rready(o1.rready), .busy(o1.busy), .done(o1.done), .pass(o1.pass),
    .err_count(o1.err_count), .status_led(o1.status_led)
  );

  sdram_axi_tester #(.BASE_ADDR(BASE2), .BURST_LEN(L), .NUM_BURSTS(N2), .SEED(SEED)) u_dut2 (
    .clk_clk(clk), .reset_reset_n(rst_n), .start(start & sel),
    .user_awid(o2.awid), .user_awaddr(o2.awaddr), .user_awlen(o2.awlen), .user_awsize(o2.awsize),
    .user_awburst(o2.awburst), .user_awvalid(o2.awvalid), .user_awready(awready),
    .user_wdata(o2.wdata), .user_wstrb(o2.wstrb), .user_wlast(o2.wlast), .user_wvalid(o2.wvalid),
    .user_wready(wready), .user_bid(bid), .user_bresp(bresp), .user_bvalid(bvalid), .user_bready(o2.bready),
    .user_arid(o2.arid), .user_araddr(o2.araddr), .user_arlen(o2.arlen), .user_arsize(o2.arsize),
    .user_arburst(o2.arburst), .user_arvalid(o2.arvalid), .user_arready(arready),
    .user_rid(rid), .user_rdata(rdata), .user_rresp(rresp), .user_rlast(rlast), .user_rvalid(rvalid),
    .user_rready(o2.rready), .busy(o2.busy), .done(o2.done), .pass(o2.pass),
    .err_count(o2.err_count), .status_led(o2.status_led)
  );

  // Knobs written only by the main sequence.
  int bp, corrupt_beat, bad_bresp_burst, bad_rid_burst, pass_id;

  // Slave state and traffic logs, written only by the slave process.
  a_log_t aw_log[$], ar_log[$];
  w_log_t w_log[$];
  logic [15:0] mem [logic [21:0]];
  int seen_pass, hold_viol, w_beat, w_burst, b_burst, r_beat, r_burst, r_gk;
  logic b_pend, b_hs, r_active, r_hs, aw_stall, w_stall, ar_stall;
  logic [21:0] cur_waddr, r_addr, ra;
  a_log_t aw_held, ar_held, a_now, ar_now;
  w_log_t w_held, w_now;

  function automatic logic rnd_go();
    return (bp != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  // AXI slave model: evaluated on the falling edge; values set here are sampled on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
      bid = 8'h0; bresp = 2'b00; rid = 8'h0; rdata = 16'h0; rresp = 2'b00; rlast = 1'b0;
      b_pend = 1'b0; b_hs = 1'b0; r_active = 1'b0; r_hs = 1'b0;
      aw_stall = 1'b0; w_stall = 1'b0; ar_stall = 1'b0;
      w_beat = 0; r_beat = 0;
    end else begin
      if (seen_pass != pass_id) begin
        seen_pass = pass_id;
        aw_log.delete(); w_log.delete(); ar_log.delete();
        hold_viol = 0; w_beat = 0; r_beat = 0; r_gk = 0;
      end
      a_now  = '{o.awid, o.awaddr, o.awlen, o.awsize, o.awburst};
      ar_now = '{o.arid, o.araddr, o.arlen, o.arsize, o.arburst};
      w_now  = '{o.wdata, o.wstrb, o.wlast};
      if (aw_stall && (!o.awvalid || a_now != aw_held)) hold_viol++;
      if (ar_stall && (!o.arvalid || ar_now != ar_held)) hold_viol++;
      if (w_stall && (!o.wvalid || w_now != w_held)) hold_viol++;

      awready = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      arready = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;

      if (b_hs) begin bvalid = 1'b0; b_pend = 1'b0; b_hs = 1'b0; end
      if (b_pend && !bvalid && rnd_go()) begin
        bvalid = 1'b1;
        bid    = 8'(b_burst);
        bresp  = (b_burst == bad_bresp_burst) ? 2'b10 : 2'b00;
      end
      b_hs = bvalid && o.bready;

      if (o.awvalid && awready) begin
        aw_log.push_back(a_now);
        cur_waddr = o.awaddr; w_beat = 0; w_burst = aw_log.size() - 1;
      end
      aw_stall = o.awvalid && !awready; aw_held = a_now;

      if (o.wvalid && wready) begin
        w_log.push_back(w_now);
        mem[22'(cur_waddr + 22'(2 * w_beat))] = o.wdata;
        w_beat++;
        if (w_beat == L) begin b_pend = 1'b1; b_burst = w_burst; end
      end
      w_stall = o.wvalid && !wready; w_held = w_now;

      if (r_hs) begin
        rvalid = 1'b0; r_hs = 1'b0; r_beat++; r_gk++;
        if (r_beat == L) begin r_beat = 0; r_active = 1'b0; end
      end
      if (r_active && !rvalid && rnd_go()) begin
        ra    = 22'(r_addr + 22'(2 * r_beat));
        rdata = mem.exists(ra) ? mem[ra] : 16'h0;
        if (r_gk == corrupt_beat) rdata = rdata ^ 16'h0001;
        rid = 8'(r_burst);
        if (r_burst == bad_rid_burst && r_beat == 0) rid = rid ^ 8'h80;
        rresp = 2'b00; rlast = (r_beat == L - 1); rvalid = 1'b1;
      end
      r_hs = rvalid && o.rready;

      if (o.arvalid && arready) begin
        ar_log.push_back(ar_now);
        r_addr = o.araddr; r_burst = ar_log.size() - 1; r_active = 1'b1; r_beat = 0;
      end
      ar_stall = o.arvalid && !arready; ar_held = ar_now;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_pass(input string tag, input bit mid_start);
    bit ok, pulsed;
    ok = 1'b0; pulsed = 1'b0;
    @(negedge clk); pass_id++; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, "_start_lat"}, {o.awvalid, o.busy, o.done}, 3'b110);
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      if (start) start = 1'b0;
      if (o.done) begin ok = 1'b1; break; end
      if (mid_start && !pulsed && o.status_led[2:0] == 3'd5 && r_beat < 6) begin
        start = 1'b1; pulsed = 1'b1;
      end
    end
    start = 1'b0;
    check({tag, "_done_in_time"}, ok, 1'b1);
    if (mid_start) check({tag, "_mid_pulse"}, pulsed, 1'b1);
  endtask

  // Reference: burst n at base + 2*L*n (mod 2^22), beat k carries SEED + k (mod 2^16).
  task automatic verify(input string tag, input int nb, input logic [21:0] base, input int exp_err);
    a_log_t ea;
    w_log_t ew;
    logic [7:0] el;
    check({tag, "_aw_cnt"}, aw_log.size(), nb);
    check({tag, "_ar_cnt"}, ar_log.size(), nb);
    for (int n = 0; n < nb; n++) begin
      ea.id = 8'(n); ea.addr = base + 22'(n * L * 2); ea.len = 8'(L - 1); ea.size = 3'b001; ea.burst = 2'b01;
      if (n < aw_log.size()) check($sformatf("%s_aw%0d", tag, n), 64'(aw_log[n]), 64'(ea));
      if (n < ar_log.size()) check($sformatf("%s_ar%0d", tag, n), 64'(ar_log[n]), 64'(ea));
    end
    check({tag, "_w_cnt"}, w_log.size(), nb * L);
    for (int kk = 0; kk < nb * L && kk < w_log.size(); kk++) begin
      ew.data = SEED + 16'(kk); ew.strb = 2'b11; ew.last = ((kk % L) == L - 1);
      check($sformatf("%s_w%0d", tag, kk), 64'(w_log[kk]), 64'(ew));
    end
    el = {(exp_err == 0), 1'b1, (exp_err != 0), 1'b0, 1'b0, 3'd6};
    check({tag, "_done_pass"}, {o.done, o.pass, o.busy}, {1'b1, (exp_err == 0), 1'b0});
    check({tag, "_err_count"}, o.err_count, 16'(exp_err));
    check({tag, "_status_led"}, o.status_led, el);
    check({tag, "_hold"}, hold_viol, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n = 1'b0; start = 1'b0; sel = 1'b0; bp = 0; pass_id = 0;
    corrupt_beat = -1; bad_bresp_burst = -1; bad_rid_burst = -1;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {o1.awvalid, o1.wvalid, o1.arvalid, o1.bready, o1.rready, o1.busy, o1.done, o1.pass}, 8'h0);
    check("rst_cnt", {o1.err_count, o1.status_led, o1.awid}, 32'h0);
    check("rst_dut2", {o2.busy, o2.done, o2.status_led}, 10'h0);
    rst_n = 1'b1;

    // Ideal slave.
    run_pass("t1", 1'b0);
    verify("t1", N1, BASE1, 0);
    if (w_log.size() == N1 * L) check("t1_last_wdata", w_log[N1 * L - 1].data, 16'hA602);
    check("t1_led", o.status_led, 8'hC6);

    // One corrupted read beat.
    corrupt_beat = 10;
    run_pass("t2", 1'b0);
    verify("t2", N1, BASE1, 1);
    check("t2_led", o.status_led, 8'h66);
    corrupt_beat = -1;

    // Random backpressure on all channels.
    bp = 1;
    run_pass("t3", 1'b0);
    verify("t3", N1, BASE1, 0);
    bp = 0;

    // Bad write response on burst 2, wrong read ID on burst 3 beat 0.
    bad_bresp_burst = 2; bad_rid_burst = 3;
    run_pass("t4", 1'b0);
    verify("t4", N1, BASE1, 2);
    bad_bresp_burst = -1; bad_rid_burst = -1;

    // Reset during the write data of burst 1.
    @(negedge clk); pass_id++; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (w_log.size() >= L + 4) begin ok = 1'b1; break; end
    end
    check("t5_reached_w1", ok, 1'b1);
    check("t5_in_w", o.status_led[2:0], 3'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_ctrl", {o1.awvalid, o1.wvalid, o1.arvalid, o1.bready, o1.rready, o1.busy, o1.done, o1.pass}, 8'h0);
    check("t5_async_cnt", {o1.err_count, o1.status_led, o1.awid}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_pass("t5", 1'b0);
    verify("t5", N1, BASE1, 0);

    // start during R is ignored.
    run_pass("t6a", 1'b1);
    verify("t6a", N1, BASE1, 0);

    // Wrapping base address on the second instance.
    sel = 1'b1;
    run_pass("t6b", 1'b0);
    verify("t6b", N2, BASE2, 0);
    if (aw_log.size() > 1) check("t6b_wrap_addr", aw_log[1].addr, 22'h000010);
    check("t6b_dut1_idle", {o1.busy, o1.done}, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
